// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier sequencer and its benches:
// FSM state encoding and default timing/width constants.
package booth_pkg;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_LOAD_CYCLES = 3;
    localparam int DEF_MUL_CYCLES  = 40;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } state_t;

    // Larger of two integers, used to size the shared LOAD/RUN counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/booth_operand_fifo.sv
// Small synchronous FIFO of {m,q} operand pairs. DEPTH must be a power of
// two (>= 2) so the pointers wrap naturally. The head entry is presented
// combinationally; the consumer registers it on pop.
module booth_operand_fifo
    import booth_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_m,
    input  logic [WIDTH-1:0] push_q,
    input  logic             pop,
    output logic [WIDTH-1:0] head_m,
    output logic [WIDTH-1:0] head_q,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [2*WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign {head_m, head_q} = mem_reg[rd_ptr_reg];

    // Storage write; data needs no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= {push_m, push_q};
        end
    end

    // Pointers and occupancy count; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/booth_mult_sequencer.sv
// Feeds operand pairs to an external Booth multiplier: buffers pairs, holds
// the multiplier in reset while operands settle, releases it for a fixed
// compute window, then captures and hands the product downstream.
module booth_mult_sequencer
    import booth_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int LOAD_CYCLES = DEF_LOAD_CYCLES,
    parameter int MUL_CYCLES  = DEF_MUL_CYCLES,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_m,
    input  logic [WIDTH-1:0]   in_q,
    output logic               mul_reset,
    output logic [WIDTH-1:0]   mul_m,
    output logic [WIDTH-1:0]   mul_q,
    input  logic [2*WIDTH-1:0] mul_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] res_data,
    output logic               busy,
    output logic [15:0]        job_count
);

    localparam int CNT_W = $clog2(max_int(LOAD_CYCLES, MUL_CYCLES)) + 1;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               mul_reset_reg;
    logic [WIDTH-1:0]   m_reg;
    logic [WIDTH-1:0]   q_reg;
    logic               res_valid_reg;
    logic [2*WIDTH-1:0] res_data_reg;
    logic [15:0]        job_count_reg;

    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [WIDTH-1:0]   head_m;
    logic [WIDTH-1:0]   head_q;

    // No pass-through: readiness comes only from registered occupancy, and
    // is withheld while reset is asserted.
    assign in_ready = !fifo_full && !reset;
    assign push     = in_valid && in_ready;
    // A new job is taken from IDLE, or straight out of HOLD on the result handshake.
    assign pop      = !fifo_empty &&
                      ((state_reg == IDLE) || ((state_reg == HOLD) && res_ready));

    assign mul_reset = mul_reset_reg;
    assign mul_m     = m_reg;
    assign mul_q     = q_reg;
    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign job_count = job_count_reg;
    assign busy      = (state_reg != IDLE) || !fifo_empty;

    booth_operand_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .srst   (reset),
        .push   (push),
        .push_m (in_m),
        .push_q (in_q),
        .pop    (pop),
        .head_m (head_m),
        .head_q (head_q),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Job sequencing FSM with registered multiplier drive and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            mul_reset_reg <= 1'b1;
            m_reg         <= '0;
            q_reg         <= '0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            job_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    mul_reset_reg <= 1'b1;
                    if (!fifo_empty) begin
                        m_reg     <= head_m;
                        q_reg     <= head_q;
                        cnt_reg   <= '0;
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    if (cnt_reg == CNT_W'(LOAD_CYCLES - 1)) begin
                        cnt_reg       <= '0;
                        mul_reset_reg <= 1'b0;
                        state_reg     <= RUN;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (cnt_reg == CNT_W'(MUL_CYCLES - 1)) begin
                        res_data_reg  <= mul_out;
                        res_valid_reg <= 1'b1;
                        mul_reset_reg <= 1'b1;
                        state_reg     <= HOLD;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        job_count_reg <= job_count_reg + 16'd1;
                        if (!fifo_empty) begin
                            m_reg     <= head_m;
                            q_reg     <= head_q;
                            cnt_reg   <= '0;
                            state_reg <= LOAD;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    mul_reset_reg <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_sequencer.sv
// Bench for booth_mult_sequencer: a behavioural multiplier stands in for
// BoothAlgo; directed steps cover latency, signed pass-through, queueing,
// backpressure and mid-run reset, then a randomized phase is scored
// against a queue of expected signed products.
module tb_booth_mult_sequencer;
    import booth_pkg::*;

    localparam int W  = DEF_WIDTH;
    localparam int LC = DEF_LOAD_CYCLES;
    localparam int MC = DEF_MUL_CYCLES;
    localparam int N_RAND = 12;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_m;
    logic [W-1:0]   in_q;
    logic           mul_reset;
    logic [W-1:0]   mul_m;
    logic [W-1:0]   mul_q;
    logic [2*W-1:0] mul_out;
    logic           res_valid;
    logic           res_ready;
    logic [2*W-1:0] res_data;
    logic           busy;
    logic [15:0]    job_count;

    int cyc     = 0;
    int n_cmp   = 0;
    int n_bad   = 0;
    int low_cnt = 0;
    logic [63:0] exp_q[$];

    booth_mult_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_m      (in_m),
        .in_q      (in_q),
        .mul_reset (mul_reset),
        .mul_m     (mul_m),
        .mul_q     (mul_q),
        .mul_out   (mul_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy),
        .job_count (job_count)
    );

    always #5 clk = ~clk;

    // Edge counter used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
    endfunction

    // Behavioural multiplier: counts cycles spent out of reset.
    always @(posedge clk) begin
        if (mul_reset) low_cnt <= 0;
        else if (low_cnt < 1000) low_cnt <= low_cnt + 1;
    end
    // Product is valid only once reset has been low for MC cycles; garbage before.
    assign mul_out = (!mul_reset && low_cnt >= MC - 1) ? smul(mul_m, mul_q)
                                                      : 64'hDEAD_BEEF_0BAD_F00D;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_one(input logic [W-1:0] m, input logic [W-1:0] q, output int acc);
        int waited;
        waited = 0;
        in_valid = 1'b1;
        in_m = m;
        in_q = q;
        while (in_ready !== 1'b1 && waited < 500) begin
            step();
            waited++;
        end
        if (in_ready !== 1'b1) chk("push_wait_ready", 64'(in_ready), 64'd1);
        step();
        acc = cyc;
        in_valid = 1'b0;
        $display("push m=0x%08h q=0x%08h accepted at edge %0d", m, q, acc);
    endtask

    task automatic wait_valid(input string tag, output int at);
        int waited;
        waited = 0;
        while (res_valid !== 1'b1 && waited < 300) begin
            step();
            waited++;
        end
        if (res_valid !== 1'b1) chk(tag, 64'(res_valid), 64'd1);
        at = cyc;
        $display("result 0x%016h valid at edge %0d", res_data, at);
    endtask

    task automatic observe_job(output int first_low, output int lows, output int valid_at);
        int waited;
        waited = 0;
        first_low = -1;
        lows = 0;
        while (res_valid !== 1'b1 && waited < 300) begin
            step();
            waited++;
            if (mul_reset === 1'b0) begin
                lows++;
                if (first_low < 0) first_low = cyc;
            end
        end
        if (res_valid !== 1'b1) chk("job_timeout", 64'(res_valid), 64'd1);
        valid_at = cyc;
        $display("result 0x%016h valid at edge %0d", res_data, valid_at);
    endtask

    initial begin
        int e0, e1, e2, fl, lows, va, va1, va2, va3, h;
        int pushed, done;
        logic acc, hs, saw;

        reset = 1'b1;
        in_valid = 1'b0;
        in_m = '0;
        in_q = '0;
        res_ready = 1'b0;
        step();
        step();
        chk("in_ready_in_reset", 64'(in_ready), 64'd0);
        reset = 1'b0;
        #1;
        chk("rst_mul_reset", 64'(mul_reset), 64'd1);
        chk("rst_mul_m", 64'(mul_m), 64'd0);
        chk("rst_mul_q", 64'(mul_q), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_data", res_data, 64'd0);
        chk("rst_job_count", 64'(job_count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);

        // Single job latency and mul_reset profile.
        res_ready = 1'b1;
        push_one(32'h00087234, 32'h00000348, e0);
        observe_job(fl, lows, va);
        chk("t1_first_low", 64'(fl - e0), 64'(1 + LC));
        chk("t1_low_cycles", 64'(lows), 64'(MC));
        chk("t1_latency", 64'(va - e0), 64'(1 + LC + MC));
        chk("t1_data", res_data, 64'h000000001BB6BAA0);
        chk("t1_mul_m", 64'(mul_m), 64'h00087234);
        chk("t1_mul_q", 64'(mul_q), 64'h00000348);
        step();
        chk("t1_valid_clear", 64'(res_valid), 64'd0);
        chk("t1_job_count", 64'(job_count), 64'd1);
        chk("t1_busy_idle", 64'(busy), 64'd0);

        // Signed operands.
        push_one(32'h50647236, 32'hB887CAAF, e0);
        push_one(32'hB887CAAF, 32'h00000001, e1);
        wait_valid("t2a_timeout", va);
        chk("t2a_data", res_data, 64'hE98E647F4142AEEA);
        step();
        wait_valid("t2b_timeout", va);
        chk("t2b_data", res_data, 64'hFFFFFFFFB887CAAF);
        step();
        chk("t2_job_count", 64'(job_count), 64'd3);

        // Back-to-back queueing from a fresh reset.
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("t3_jc_after_reset", 64'(job_count), 64'd0);
        push_one(32'hFFFFFEFD, 32'hFFFFFEFD, e0);
        push_one(32'h00000000, 32'h50647236, e1);
        push_one(32'hB887CAAF, 32'h00000000, e2);
        chk("t3_accept_spacing_1", 64'(e1 - e0), 64'd1);
        chk("t3_accept_spacing_2", 64'(e2 - e1), 64'd1);
        in_valid = 1'b1;
        in_m = 32'h00001234;
        in_q = 32'h00005678;
        #1;
        chk("t3_fourth_push_blocked", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        wait_valid("t3a_timeout", va1);
        chk("t3a_data", res_data, 64'h0000000000010609);
        chk("t3a_latency", 64'(va1 - e0), 64'(1 + LC + MC));
        step();
        wait_valid("t3b_timeout", va2);
        chk("t3b_data", res_data, 64'd0);
        chk("t3b_spacing", 64'(va2 - va1), 64'(1 + LC + MC));
        step();
        wait_valid("t3c_timeout", va3);
        chk("t3c_data", res_data, 64'd0);
        chk("t3c_spacing", 64'(va3 - va2), 64'(1 + LC + MC));
        step();
        chk("t3_job_count", 64'(job_count), 64'd3);

        // Backpressure: result held, next job waits for the handshake.
        res_ready = 1'b0;
        push_one(32'h7FFFFFFF, 32'h7FFFFFFF, e0);
        push_one(32'h80000000, 32'h80000000, e1);
        wait_valid("t4a_timeout", va);
        chk("t4a_data", res_data, 64'h3FFFFFFF00000001);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t4_hold_data", res_data, 64'h3FFFFFFF00000001);
            chk("t4_hold_mul_reset", 64'(mul_reset), 64'd1);
            chk("t4_hold_valid", 64'(res_valid), 64'd1);
        end
        res_ready = 1'b1;
        step();
        h = cyc;
        chk("t4_valid_clear", 64'(res_valid), 64'd0);
        chk("t4_pop_m", 64'(mul_m), 64'h80000000);
        chk("t4_pop_q", 64'(mul_q), 64'h80000000);
        chk("t4_job_count", 64'(job_count), 64'd4);
        wait_valid("t4b_timeout", va);
        chk("t4b_latency", 64'(va - h), 64'(LC + MC));
        chk("t4b_data", res_data, 64'h4000000000000000);
        step();

        // Reset 20 cycles into RUN with one pair queued.
        push_one(32'h00001111, 32'h00002222, e0);
        push_one(32'h00003333, 32'h00004444, e1);
        while (cyc < e0 + 1 + LC + 20) step();
        chk("t5_in_run", 64'(mul_reset), 64'd0);
        chk("t5_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        step();
        chk("t5_in_ready_during_reset", 64'(in_ready), 64'd0);
        reset = 1'b0;
        #1;
        chk("t5_in_ready_after", 64'(in_ready), 64'd1);
        chk("t5_job_count", 64'(job_count), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_mul_reset", 64'(mul_reset), 64'd1);
        saw = 1'b0;
        for (int i = 0; i < 120; i++) begin
            step();
            if (res_valid === 1'b1) saw = 1'b1;
        end
        chk("t5_no_valid", 64'(saw), 64'd0);
        chk("t5_job_count_late", 64'(job_count), 64'd0);

        // Randomized traffic scored against the expected-product queue.
        pushed = 0;
        done = 0;
        exp_q.delete();
        for (int c = 0; c < 5000 && done < N_RAND; c++) begin
            if (!in_valid && pushed < N_RAND && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b1;
                in_m = $urandom;
                in_q = $urandom;
                if ($urandom_range(0, 5) == 0) in_m = 32'h80000000;
                if ($urandom_range(0, 5) == 0) in_q = 32'hFFFFFFFF;
            end
            res_ready = ($urandom_range(0, 2) != 0);
            acc = in_valid && in_ready;
            hs = res_valid && res_ready;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    chk("t6_unexpected_result", 64'(res_valid), 64'd0);
                end else begin
                    chk("t6_result", res_data, exp_q.pop_front());
                end
                done++;
                $display("rand result %0d: 0x%016h", done, res_data);
            end
            if (acc) begin
                exp_q.push_back(smul(in_m, in_q));
                pushed++;
                $display("rand push %0d: m=0x%08h q=0x%08h", pushed, in_m, in_q);
            end
            step();
            if (acc) in_valid = 1'b0;
        end
        chk("t6_done", 64'(done), 64'(N_RAND));
        chk("t6_job_count", 64'(job_count), 64'(N_RAND));
        chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
